muldiv_unit: RTL

Iterative multiply/divide execution unit with architectural HI/LO registers, extending the single-cycle ALU control path for the MIPS core. It decodes the R-type `funct` field for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. Multiply and divide run as a radix-2 shift/add or restoring loop under a start/busy/done handshake. The EX stage holds its instruction while `busy` is high.

---
 rtl/muldiv_unit.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide execution unit with HI/LO registers.
// MULT/MULTU use a radix-2 shift/add loop and DIV/DIVU use a restoring loop.
// Each loop produces one bit per cycle over WIDTH cycles.
// A single sign fix-up cycle follows the loop.
// MFHI/MFLO/MTHI/MTLO complete on the accepting edge.
// Optional feature: define MULDIV_DZ_TRAP_EN to trap divide-by-zero.
// The trap adds the dz output port.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MULDIV_DZ_TRAP_EN
   ,
   output logic             dz
`endif
);

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_next;

   // Iteration state: opnd is the multiplicand or divisor magnitude.
   // For multiply, {acc, shreg} is the running product and shreg starts as the multiplier.
   // For divide, acc is the remainder and shreg shifts the dividend out while quotient bits shift in.
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] shreg;
   logic             sign_a;
   logic             sign_b;
   logic             is_div;

   // Control strobes from the next-state logic
   logic load;
   logic write_mf;
   logic write_mt;
   logic done_next;
   logic illegal_next;
`ifdef MULDIV_DZ_TRAP_EN
   logic dz_next;
   logic b_zero;
   assign b_zero = (b == '0);
`endif

   // Operand decode and magnitude extraction for the signed variants
   logic             op_signed;
   logic             op_div;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   assign op_signed = (funct == F_MULT) || (funct == F_DIV);
   assign op_div    = (funct == F_DIV)  || (funct == F_DIVU);
   assign a_neg     = op_signed & a[WIDTH-1];
   assign b_neg     = op_signed & b[WIDTH-1];
   assign a_mag     = a_neg ? (WIDTH'(0) - a) : a;
   assign b_mag     = b_neg ? (WIDTH'(0) - b) : b;

   // One multiply step: conditional add of the multiplicand, then shift right
   // with the carry entering the top of the product.
   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

   // One restoring-divide step: shift the next dividend bit into the remainder
   // and trial-subtract. The partial remainder stays below the divisor, so the
   // WIDTH-bit difference is exact whenever the subtraction succeeds.
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_trial;
   logic             div_ok;
   assign div_shift = {acc, shreg[WIDTH-1]};
   assign div_trial = div_shift[WIDTH-1:0] - opnd;
   assign div_ok    = (div_shift >= {1'b0, opnd});

   // Sign fix-up: product and quotient negate on differing signs, remainder follows a
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   assign prod     = {acc, shreg};
   assign prod_fix = (sign_a ^ sign_b) ? ({(2*WIDTH){1'b0}} - prod) : prod;
   assign quo_fix  = (sign_a ^ sign_b) ? (WIDTH'(0) - shreg) : shreg;
   assign rem_fix  = sign_a ? (WIDTH'(0) - acc) : acc;

   assign busy = (state != IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and per-cycle control strobes
   always_comb begin
      state_next   = state;
      load         = 1'b0;
      write_mf     = 1'b0;
      write_mt     = 1'b0;
      done_next    = 1'b0;
      illegal_next = 1'b0;
`ifdef MULDIV_DZ_TRAP_EN
      dz_next      = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               case (funct)
                  F_MFHI, F_MFLO: begin
                     write_mf  = 1'b1;
                     done_next = 1'b1;
                  end
                  F_MTHI, F_MTLO: begin
                     write_mt  = 1'b1;
                     done_next = 1'b1;
                  end
                  F_MULT, F_MULTU: begin
                     load       = 1'b1;
                     state_next = CALC;
                  end
                  F_DIV, F_DIVU: begin
`ifdef MULDIV_DZ_TRAP_EN
                     if (b_zero) begin
                        dz_next   = 1'b1;
                        done_next = 1'b1;
                     end else begin
                        load       = 1'b1;
                        state_next = CALC;
                     end
`else
                     load       = 1'b1;
                     state_next = CALC;
`endif
                  end
                  default: begin
                     illegal_next = 1'b1;
                  end
               endcase
            end
         end
         CALC: begin
            illegal_next = start;
            if (count == '0) begin
               state_next = FIX;
            end
         end
         FIX: begin
            illegal_next = start;
            done_next    = 1'b1;
            state_next   = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Registered single-cycle status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done    <= 1'b0;
         illegal <= 1'b0;
`ifdef MULDIV_DZ_TRAP_EN
         dz      <= 1'b0;
`endif
      end else begin
         done    <= done_next;
         illegal <= illegal_next;
`ifdef MULDIV_DZ_TRAP_EN
         dz      <= dz_next;
`endif
      end
   end

   // Iterative datapath: operand latch on accept, one bit per CALC cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         opnd   <= '0;
         acc    <= '0;
         shreg  <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         is_div <= 1'b0;
      end else if (load) begin
         count  <= CNT_INIT;
         opnd   <= op_div ? b_mag : a_mag;
         acc    <= '0;
         shreg  <= op_div ? a_mag : b_mag;
         sign_a <= a_neg;
         sign_b <= b_neg;
         is_div <= op_div;
      end else if (state == CALC) begin
         count <= count - 1'b1;
         if (is_div) begin
            acc   <= div_ok ? div_trial : div_shift[WIDTH-1:0];
            shreg <= {shreg[WIDTH-2:0], div_ok};
         end else begin
            acc   <= mul_sum[WIDTH:1];
            shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
         end
      end
   end

   // Architectural HI/LO and the MFHI/MFLO read register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi     <= '0;
         lo     <= '0;
         result <= '0;
      end else begin
         if (write_mf) begin
            result <= funct[1] ? lo : hi;
         end
         if (write_mt) begin
            if (funct[1]) begin
               lo <= a;
            end else begin
               hi <= a;
            end
         end
         if (state == FIX) begin
            if (is_div) begin
               hi <= rem_fix;
               lo <= quo_fix;
            end else begin
               hi <= prod_fix[2*WIDTH-1:WIDTH];
               lo <= prod_fix[WIDTH-1:0];
            end
         end
      end
   end

endmodule
